// File: rtl/servo_pulse_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : servo_pkg
// Brief    : Shared types, default constants and position quantiser for the
//            servo pulse monitor and its software register map.
// Revision : 1.0 - initial release
// ============================================================================
package servo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int c_CLK_PER_US   = 50;
    localparam int c_MIN_US       = 1000;
    localparam int c_POS_SHIFT    = 2;
    localparam int c_MIN_PULSE_US = 10;
    localparam int c_TIMEOUT_US   = 25000;

    // Bit positions inside the status byte; the software header generator reads these.
    localparam int c_STAT_MEAS_VALID  = 0;
    localparam int c_STAT_TIMEOUT     = 1;
    localparam int c_STAT_UNDER_RANGE = 2;
    localparam int c_STAT_OVER_RANGE  = 3;
    localparam int c_STAT_GLITCH_SEEN = 4;

    typedef struct packed {
        logic [7:0] code;
        logic       under;
        logic       over;
    } pos_res_t;

    function automatic pos_res_t pos_quantise(
        input logic [15:0] width,
        input logic [15:0] min_us,
        input int          shift
    );
        pos_res_t    res;
        logic [15:0] q;
        res = '0;
        q   = '0;
        if (width < min_us) begin
            res.under = 1'b1;
        end else begin
            q = (width - min_us) >> shift;
            if (q > 16'd255) begin
                res.code = 8'hFF;
                res.over = 1'b1;
            end else begin
                res.code = q[7:0];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_pulse_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : servo_pulse_monitor_if
// Brief    : Pin input and measurement results of the servo pulse monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface servo_pulse_monitor_if;

    logic        pwm_in;
    logic [15:0] width_us;
    logic [15:0] period_us;
    logic [7:0]  pos_code;
    logic        meas_done;
    logic [7:0]  status;

    // master: the monitor itself; slave: the pin driver / register consumer
    modport master (
        input  pwm_in,
        output width_us,
        output period_us,
        output pos_code,
        output meas_done,
        output status
    );

    modport slave (
        output pwm_in,
        input  width_us,
        input  period_us,
        input  pos_code,
        input  meas_done,
        input  status
    );

endinterface
`default_nettype wire

// File: rtl/servo_pulse_monitor_us_tick.sv
`default_nettype none
// ============================================================================
// Module   : servo_us_tick
// Brief    : Microsecond prescaler with synchronous restart; ticks on wrap.
// Revision : 1.0 - initial release
// ============================================================================
module servo_us_tick #(
    parameter int CLK_PER_US = 50
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  i_restart,
    output logic o_tick
);

    localparam int              c_PW   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [c_PW-1:0] c_LAST = c_PW'(CLK_PER_US - 1);
    localparam logic [c_PW-1:0] c_ONE  = c_PW'(1);

    logic [c_PW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    // A wrap coinciding with a restart still counts toward the closing interval.
    assign o_tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/servo_pulse_monitor.sv
`default_nettype none
// ============================================================================
// Module   : servo_pulse_monitor
// Brief    : Measures servo PWM high-time and period, quantises position and
//            flags loss of signal, range errors and glitches.
// Revision : 1.0 - initial release
// ============================================================================
module servo_pulse_monitor
    import servo_pkg::*;
#(
    parameter int CLK_PER_US   = c_CLK_PER_US,
    parameter int MIN_US       = c_MIN_US,
    parameter int POS_SHIFT    = c_POS_SHIFT,
    parameter int MIN_PULSE_US = c_MIN_PULSE_US,
    parameter int TIMEOUT_US   = c_TIMEOUT_US
) (
    input  wire                   clk,
    input  wire                   rst_n,
    servo_pulse_monitor_if.master mon
);

    localparam logic [15:0]      c_MIN_US16    = 16'(MIN_US);
    localparam logic [15:0]      c_MIN_PULSE16 = 16'(MIN_PULSE_US);
    localparam logic [15:0]      c_SAT         = 16'hFFFF;
    localparam int               c_IW          = $clog2(TIMEOUT_US + 1);
    localparam logic [c_IW-1:0]  c_TO          = c_IW'(TIMEOUT_US);
    localparam logic [c_IW-1:0]  c_TO_M1       = c_IW'(TIMEOUT_US - 1);
    localparam logic [c_IW-1:0]  c_IONE        = c_IW'(1);

    logic             r_sync1, r_sync2, r_sync3;
    logic [1:0]       r_fill;
    logic             w_edge_ok, w_rise, w_fall, w_tick, w_timeout;
    state_t           r_state, w_state_nxt;
    logic             w_accept, w_glitch, w_latch_hi, w_close;
    logic [15:0]      r_hi_cnt, r_per_cnt, r_hi_lat, r_per_lat;
    logic [15:0]      w_hi_inc, w_per_inc;
    logic [c_IW-1:0]  r_idle_cnt;
    logic             r_pend;
    logic [15:0]      r_width, r_period;
    logic [7:0]       r_pos;
    logic             r_meas_done, r_meas_valid, r_timeout, r_under, r_over, r_glitch;
    logic [7:0]       w_status;
    pos_res_t         w_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_fill  <= 2'd0;
        end else begin
            r_sync1 <= mon.pwm_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
        end
    end

    // Edges are ignored until the synchroniser holds real samples, so a line
    // already high when reset releases does not look like a rising edge.
    assign w_edge_ok = (r_fill == 2'd3);
    assign w_rise    = w_edge_ok &  r_sync2 & ~r_sync3;
    assign w_fall    = w_edge_ok & ~r_sync2 &  r_sync3;

    servo_us_tick #(
        .CLK_PER_US (CLK_PER_US)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (w_accept),
        .o_tick    (w_tick)
    );

    assign w_hi_inc  = (w_tick && (r_hi_cnt  != c_SAT)) ? r_hi_cnt  + 16'd1 : r_hi_cnt;
    assign w_per_inc = (w_tick && (r_per_cnt != c_SAT)) ? r_per_cnt + 16'd1 : r_per_cnt;
    assign w_timeout = w_tick && (r_idle_cnt == c_TO_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Timeout has priority over any edge seen in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_glitch    = 1'b0;
        w_latch_hi  = 1'b0;
        w_close     = 1'b0;
        if (w_timeout) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        w_accept    = 1'b1;
                        w_state_nxt = HIGH;
                    end
                end
                HIGH: begin
                    if (w_fall) begin
                        if (w_hi_inc < c_MIN_PULSE16) begin
                            w_glitch    = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_latch_hi  = 1'b1;
                            w_state_nxt = LOW;
                        end
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        w_accept    = 1'b1;
                        w_close     = 1'b1;
                        w_state_nxt = HIGH;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_cnt   <= '0;
            r_per_cnt  <= '0;
            r_idle_cnt <= '0;
            r_hi_lat   <= '0;
            r_per_lat  <= '0;
            r_pend     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hi_cnt   <= '0;
                r_per_cnt  <= '0;
                r_idle_cnt <= '0;
            end else begin
                if (r_state == HIGH) r_hi_cnt <= w_hi_inc;
                if (r_state != IDLE) r_per_cnt <= w_per_inc;
                if (w_tick && (r_idle_cnt != c_TO)) r_idle_cnt <= r_idle_cnt + c_IONE;
            end
            if (w_latch_hi) r_hi_lat <= w_hi_inc;
            if (w_close) r_per_lat <= w_per_inc;
            r_pend <= w_close;
        end
    end

    assign w_pos = pos_quantise(r_hi_lat, c_MIN_US16, POS_SHIFT);

    // Results publish one cycle after the closing rise, from the latched counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_width      <= '0;
            r_period     <= '0;
            r_pos        <= '0;
            r_meas_done  <= 1'b0;
            r_meas_valid <= 1'b0;
            r_timeout    <= 1'b0;
            r_under      <= 1'b0;
            r_over       <= 1'b0;
            r_glitch     <= 1'b0;
        end else begin
            r_meas_done <= r_pend;
            if (r_pend) begin
                r_width      <= r_hi_lat;
                r_period     <= r_per_lat;
                r_pos        <= w_pos.code;
                r_under      <= w_pos.under;
                r_over       <= w_pos.over;
                r_meas_valid <= 1'b1;
                r_timeout    <= 1'b0;
            end else if (w_timeout) begin
                r_meas_valid <= 1'b0;
                r_timeout    <= 1'b1;
            end
            if (w_glitch) r_glitch <= 1'b1;
        end
    end

    always_comb begin
        w_status                     = '0;
        w_status[c_STAT_MEAS_VALID]  = r_meas_valid;
        w_status[c_STAT_TIMEOUT]     = r_timeout;
        w_status[c_STAT_UNDER_RANGE] = r_under;
        w_status[c_STAT_OVER_RANGE]  = r_over;
        w_status[c_STAT_GLITCH_SEEN] = r_glitch;
    end

    assign mon.width_us  = r_width;
    assign mon.period_us = r_period;
    assign mon.pos_code  = r_pos;
    assign mon.meas_done = r_meas_done;
    assign mon.status    = w_status;

endmodule
`default_nettype wire

// File: tb/tb_servo_pulse_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_servo_pulse_monitor
// Brief    : Directed self-checking bench for servo_pulse_monitor, run with a
//            scaled time base (3 clk/us, 200 us zero, 1500 us timeout).
// Revision : 1.0 - initial release
// ============================================================================
module tb_servo_pulse_monitor;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   d_ref    = 0;

    servo_pulse_monitor_if mon_if ();

    servo_pulse_monitor #(
        .CLK_PER_US   (3),
        .MIN_US       (200),
        .POS_SHIFT    (2),
        .MIN_PULSE_US (10),
        .TIMEOUT_US   (1500)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (mon_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_if.meas_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_meas(input string tag, input int w, input int p, input int pc, input int st);
        chk({tag, "_width"},  32'(mon_if.width_us),  32'(w));
        chk({tag, "_period"}, 32'(mon_if.period_us), 32'(p));
        chk({tag, "_pos"},    32'(mon_if.pos_code),  32'(pc));
        chk({tag, "_status"}, 32'(mon_if.status),    32'(st));
    endtask

    task automatic chk_zero(input string tag);
        chk_meas(tag, 0, 0, 0, 0);
        chk({tag, "_done"}, 32'(mon_if.meas_done), 32'd0);
    endtask

    task automatic hi(input int n);
        mon_if.pwm_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic lo(input int n);
        mon_if.pwm_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        mon_if.pwm_in = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        lo(10);

        // Three 700 us / 1000 us periods, then the closing rise.
        d_ref = done_cnt;
        hi(2100); lo(900);
        hi(2100); lo(900);
        hi(2100); lo(900);
        hi(6);
        chk("train_done_count", 32'(done_cnt - d_ref), 32'd3);
        chk_meas("nominal", 700, 1000, 125, 8'h01);

        // 2110 cycles high -> 703 us; 3010 cycles period -> 1003 us.
        hi(2104); lo(900); hi(6);
        chk_meas("floor", 703, 1003, 125, 8'h01);

        // 450 cycles high -> 150 us, below the 200 us zero point.
        hi(444); lo(2550); hi(6);
        chk_meas("under", 150, 1000, 0, 8'h05);

        // 3900 cycles high -> 1300 us: (1300-200)>>2 = 275, clamps to 255.
        hi(3894); lo(300); hi(6);
        chk_meas("over", 1300, 1400, 255, 8'h09);

        hi(2094); lo(900); hi(6);
        chk_meas("recover_range", 700, 1000, 125, 8'h01);

        // Spike: its rise closes the previous period (2500 cycles -> 833 us).
        hi(2094); lo(400);
        hi(6);
        lo(494);
        chk_meas("spike", 700, 833, 125, 8'h11);
        d_ref = done_cnt;
        hi(2100); lo(900);
        chk("spike_no_done", 32'(done_cnt - d_ref), 32'd0);
        hi(6);
        chk("post_spike_done", 32'(done_cnt - d_ref), 32'd1);
        chk_meas("post_spike", 700, 1000, 125, 8'h11);

        // Line stops low; timeout lands 4500 cycles after the last accepted rise.
        hi(2094); lo(2390);
        chk("pre_timeout_status", 32'(mon_if.status), 32'h11);
        lo(20);
        chk_meas("timeout", 700, 1000, 125, 8'h12);
        hi(2100);
        chk("timeout_sticky", 32'(mon_if.status), 32'h12);
        lo(900); hi(6);
        chk_meas("timeout_clear", 700, 1000, 125, 8'h11);

        // Reset in the middle of a high phase.
        hi(1000);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hi(1094); lo(900);
        d_ref = done_cnt;
        hi(2100); lo(900);
        chk("post_reset_no_done", 32'(done_cnt - d_ref), 32'd0);
        hi(6);
        chk("post_reset_done", 32'(done_cnt - d_ref), 32'd1);
        chk_meas("post_reset", 700, 1000, 125, 8'h01);
        lo(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
